rst_seq_ctrl: RTL

- Parametrised reset/lock sequencer; successor to the single-chain clock/reset generator.
- Brings up a chain of NUM_PLL cascaded clock managers one at a time; each manager's reset is held until the previous one reports lock.
- Releases NUM_DOM downstream reset domains in staggered order, with lock-timeout retry, lock-loss recovery and soft reset.
- Sits at the top of the clock tree, between the DCM/PLL instances and every synchronous subsystem.

---
 rtl/rst_seq_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset/lock sequencer for a chain of cascaded clock managers.
// Each manager is brought up in turn: its reset is pulsed, then the
// sequencer waits for its synchronised lock, retrying on timeout and
// giving up in FAULT after MAX_RETRY attempts. Once every manager is
// locked, the downstream reset domains are released one after another,
// STAGGER cycles apart. Loss of lock restarts bring-up from the lowest
// unlocked manager; a soft reset re-runs only the domain release.
//
// Ports:
//   clk_nodelay   system clock, all logic on the rising edge
//   masterRst     asynchronous active-high reset
//   pll_locked    lock indicators, asynchronous, one per manager
//   soft_rst_req  single-cycle request to re-run the domain release
//   pll_rst       manager resets, active high
//   domain_rst    domain resets, active high, bit 0 released first
//   ready         high while every domain is running
//   fault         high once bring-up has failed (terminal)
//   lock_lost     sticky flag, set by any lock drop after bring-up
//   retry_cnt     attempts used on the current manager
module rst_seq_ctrl #(
  parameter int unsigned NUM_PLL      = 2,
  parameter int unsigned NUM_DOM      = 4,
  parameter int unsigned SYNC_DEPTH   = 3,
  parameter int unsigned PLL_RST_LEN  = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned STAGGER      = 8
) (
  input  logic               clk_nodelay,
  input  logic               masterRst,
  input  logic [NUM_PLL-1:0] pll_locked,
  input  logic               soft_rst_req,
  output logic [NUM_PLL-1:0] pll_rst,
  output logic [NUM_DOM-1:0] domain_rst,
  output logic               ready,
  output logic               fault,
  output logic               lock_lost,
  output logic [3:0]         retry_cnt
);

  localparam int unsigned KW      = (NUM_PLL > 1) ? $clog2(NUM_PLL) : 1;
  localparam int unsigned REL_LEN = STAGGER * NUM_DOM;
  localparam int unsigned TMAX    = (LOCK_TIMEOUT > REL_LEN) ? LOCK_TIMEOUT : REL_LEN;
  localparam int unsigned TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } state_e;

  // Flop state and next-state values
  logic [SYNC_DEPTH-1:0][NUM_PLL-1:0] sync_q, sync_d;
  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           retry_q, retry_d;
  logic [NUM_PLL-1:0]   pll_rst_q, pll_rst_d;
  logic [NUM_DOM-1:0]   domain_rst_q, domain_rst_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;
  logic                 lock_lost_q, lock_lost_d;

  // Combinational helpers
  logic [NUM_PLL-1:0]   lk;
  logic [KW-1:0]        lost_idx;
  logic [TW-1:0]        timer_inc;
  logic                 in_service;

  // Synchronised lock vector; every decision below looks only at this
  assign lk = sync_q[SYNC_DEPTH-1];

  // Next-state, counters and registered outputs
  always_comb begin
    sync_d       = {sync_q[SYNC_DEPTH-2:0], pll_locked};
    state_d      = state_q;
    k_d          = k_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    domain_rst_d = domain_rst_q;
    lock_lost_d  = lock_lost_q;
    pll_rst_d    = '1;
    lost_idx     = '0;

    // Timer saturates so a long stay in one state never wraps it
    timer_inc  = (timer_q == '1) ? timer_q : timer_q + TW'(1);
    in_service = (state_q == ST_RELEASE) || (state_q == ST_RUN);

    // Lowest unlocked manager; scanning downwards leaves the smallest index
    for (int i = NUM_PLL - 1; i >= 0; i--) begin
      if (!lk[i]) lost_idx = KW'(i);
    end

    // Manager resets follow the state held during this cycle, so they
    // trail the state register by one edge
    case (state_q)
      ST_PLL_RST, ST_WAIT_LOCK: begin
        for (int unsigned i = 0; i < NUM_PLL; i++) begin
          if (KW'(i) < k_q)       pll_rst_d[i] = 1'b0;
          else if (KW'(i) == k_q) pll_rst_d[i] = (state_q == ST_PLL_RST);
          else                    pll_rst_d[i] = 1'b1;
        end
      end
      ST_RELEASE, ST_RUN: pll_rst_d = '0;
      default:            pll_rst_d = '1;
    endcase

    if (in_service && (lk != '1)) begin
      // Lock drop overrides any soft reset or release progress
      lock_lost_d  = 1'b1;
      domain_rst_d = '1;
      k_d          = lost_idx;
      retry_d      = '0;
      timer_d      = '0;
      state_d      = ST_PLL_RST;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (timer_q == TW'(PLL_RST_LEN - 1)) begin
            state_d = ST_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested before timeout so a coincident lock still advances
          if (lk[k_q]) begin
            timer_d = '0;
            if (k_q == KW'(NUM_PLL - 1)) begin
              state_d = ST_RELEASE;
            end else begin
              k_d     = k_q + KW'(1);
              retry_d = '0;
              state_d = ST_PLL_RST;
            end
          end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            retry_d = retry_q + 4'd1;
            timer_d = '0;
            state_d = (retry_d == 4'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
          end else begin
            timer_d = timer_inc;
          end
        end

        ST_RELEASE: begin
          if (soft_rst_req) begin
            timer_d      = '0;
            domain_rst_d = '1;
          end else if (!domain_rst_q[NUM_DOM-1]) begin
            // Last domain came out of reset on the previous edge
            state_d = ST_RUN;
          end else begin
            for (int unsigned j = 0; j < NUM_DOM; j++) begin
              if (timer_q == TW'(STAGGER * (j + 1) - 1)) domain_rst_d[j] = 1'b0;
            end
            timer_d = timer_inc;
          end
        end

        ST_RUN: begin
          if (soft_rst_req) begin
            domain_rst_d = '1;
            timer_d      = '0;
            state_d      = ST_RELEASE;
          end
        end

        ST_FAULT: begin
          domain_rst_d = '1;
        end

        default: begin
          state_d = ST_FAULT;
        end
      endcase
    end

    // Status flags track the state being entered
    ready_d = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  // State register; everything resets asynchronously
  always_ff @(posedge clk_nodelay or posedge masterRst) begin
    if (masterRst) begin
      sync_q       <= '0;
      state_q      <= ST_PLL_RST;
      k_q          <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      pll_rst_q    <= '1;
      domain_rst_q <= '1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      k_q          <= k_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      pll_rst_q    <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
      lock_lost_q  <= lock_lost_d;
    end
  end

  assign pll_rst    = pll_rst_q;
  assign domain_rst = domain_rst_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign lock_lost  = lock_lost_q;
  assign retry_cnt  = retry_q;

endmodule
